// File: rtl/mem_load_if.sv
// Request, memory-read and response signals of the load unit.
// The unit connects through the slave modport and the requester through the master modport.
interface mem_load_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RD_WIDTH   = 5
);
  logic                  req_valid_in;
  logic                  req_ready_out;
  logic [ADDR_WIDTH-1:0] req_addr_in;
  logic [2:0]            req_func_in;
  logic [RD_WIDTH-1:0]   req_rd_in;
  logic                  mem_en_out;
  logic [ADDR_WIDTH-1:0] mem_addr_out;
  logic [DATA_WIDTH-1:0] mem_rdata_in;
  logic                  resp_valid_out;
  logic                  resp_ready_in;
  logic [DATA_WIDTH-1:0] resp_data_out;
  logic [RD_WIDTH-1:0]   resp_rd_out;

  modport slave (
    input  req_valid_in, req_addr_in, req_func_in, req_rd_in, mem_rdata_in, resp_ready_in,
    output req_ready_out, mem_en_out, mem_addr_out, resp_valid_out, resp_data_out, resp_rd_out
  );

  modport master (
    output req_valid_in, req_addr_in, req_func_in, req_rd_in, mem_rdata_in, resp_ready_in,
    input  req_ready_out, mem_en_out, mem_addr_out, resp_valid_out, resp_data_out, resp_rd_out
  );
endinterface

// File: rtl/mem_load_unit.sv
// Single-outstanding load unit: word-aligned read of a synchronous data memory,
// byte/halfword/word extraction with sign or zero extension, valid/ready result.
module mem_load_unit #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter int RD_WIDTH     = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  mem_load_if.slave   bus,
  output logic        busy_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [2:0] F_LB  = 3'b000;
  localparam logic [2:0] F_LH  = 3'b001;
  localparam logic [2:0] F_LBU = 3'b100;
  localparam logic [2:0] F_LHU = 3'b101;

  state_t                state;
  logic [3:0]            cnt;
  logic [1:0]            off;
  logic [2:0]            func;
  logic [RD_WIDTH-1:0]   rd;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  resp_valid;
  logic                  busy;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] byte_shift;
  logic [DATA_WIDTH-1:0] half_shift;

  assign bus.req_ready_out  = rst_n && (state == S_IDLE);
  assign bus.mem_en_out     = bus.req_valid_in && bus.req_ready_out;
  assign bus.mem_addr_out   = {bus.req_addr_in[ADDR_WIDTH-1:2], 2'b00};
  assign bus.resp_valid_out = resp_valid;
  assign bus.resp_data_out  = resp_data;
  assign bus.resp_rd_out    = rd;
  assign busy_out           = busy;

  // Halfword offset rounds down to an even byte, matching the store side.
  assign byte_shift = bus.mem_rdata_in >> {off, 3'b000};
  assign half_shift = bus.mem_rdata_in >> {off[1], 4'b0000};

  always_comb begin
    // NOTE: default first so every path assigns load_data and no latch is inferred.
    load_data = bus.mem_rdata_in;
    case (func)
      F_LB:    load_data = {{(DATA_WIDTH-8){byte_shift[7]}}, byte_shift[7:0]};
      F_LBU:   load_data = {{(DATA_WIDTH-8){1'b0}}, byte_shift[7:0]};
      F_LH:    load_data = {{(DATA_WIDTH-16){half_shift[15]}}, half_shift[15:0]};
      F_LHU:   load_data = {{(DATA_WIDTH-16){1'b0}}, half_shift[15:0]};
      default: load_data = bus.mem_rdata_in;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      off        <= '0;
      func       <= '0;
      rd         <= '0;
      resp_data  <= '0;
      resp_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid_in) begin
            off   <= bus.req_addr_in[1:0];
            func  <= bus.req_func_in;
            rd    <= bus.req_rd_in;
            cnt   <= 4'(READ_LATENCY - 1);
            busy  <= 1'b1;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            resp_data  <= load_data;
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.resp_ready_in) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_load_unit.sv
// Directed bench for mem_load_unit with one instance at READ_LATENCY=1 and one at 3,
// each fed by a small latency-matched memory model.
module tb_mem_load_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        v1, v3;
  logic [31:0] addr;
  logic [2:0]  func;
  logic [4:0]  rd;
  logic        resp_ready;
  logic        sel3;
  logic        busy1, busy3;
  int          n_cmp = 0;
  int          n_bad = 0;

  mem_load_if a1 ();
  mem_load_if a3 ();

  mem_load_unit #(.READ_LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(a1), .busy_out(busy1));
  mem_load_unit #(.READ_LATENCY(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(a3), .busy_out(busy3));

  assign a1.req_valid_in  = v1;
  assign a1.req_addr_in   = addr;
  assign a1.req_func_in   = func;
  assign a1.req_rd_in     = rd;
  assign a1.resp_ready_in = resp_ready;
  assign a3.req_valid_in  = v3;
  assign a3.req_addr_in   = addr;
  assign a3.req_func_in   = func;
  assign a3.req_rd_in     = rd;
  assign a3.resp_ready_in = resp_ready;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h100) return 32'h8070F0A5;
    if (a == 32'h200) return 32'h12345678;
    return 32'h0;
  endfunction

  // Memory models: data valid exactly READ_LATENCY cycles after mem_en, garbage otherwise.
  logic        p1_v;
  logic [31:0] p1_a;
  logic [2:0]  p3_v;
  logic [31:0] p3_a [3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_v <= 1'b0;
      p3_v <= 3'b000;
    end else begin
      p1_v    <= a1.mem_en_out;
      p1_a    <= a1.mem_addr_out;
      p3_v    <= {p3_v[1:0], a3.mem_en_out};
      p3_a[0] <= a3.mem_addr_out;
      p3_a[1] <= p3_a[0];
      p3_a[2] <= p3_a[1];
    end
  end

  assign a1.mem_rdata_in = p1_v    ? mem_word(p1_a)    : 32'hDEADBEEF;
  assign a3.mem_rdata_in = p3_v[2] ? mem_word(p3_a[2]) : 32'hDEADBEEF;

  logic        s_ready, s_en, s_rvalid, s_busy;
  logic [31:0] s_addr, s_data;
  logic [4:0]  s_rd;
  assign s_ready  = sel3 ? a3.req_ready_out  : a1.req_ready_out;
  assign s_en     = sel3 ? a3.mem_en_out     : a1.mem_en_out;
  assign s_addr   = sel3 ? a3.mem_addr_out   : a1.mem_addr_out;
  assign s_rvalid = sel3 ? a3.resp_valid_out : a1.resp_valid_out;
  assign s_data   = sel3 ? a3.resp_data_out  : a1.resp_data_out;
  assign s_rd     = sel3 ? a3.resp_rd_out    : a1.resp_rd_out;
  assign s_busy   = sel3 ? busy3             : busy1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic issue(input bit use3, input logic [31:0] a, input logic [2:0] f, input logic [4:0] r);
    sel3 = use3;
    @(negedge clk);
    addr = a;
    func = f;
    rd   = r;
    if (use3) v3 = 1'b1;
    else      v1 = 1'b1;
    #1;
    check("req_ready idle", s_ready, 1);
    check("mem_en accept", s_en, 1);
    check("mem_addr aligned", s_addr, {a[31:2], 2'b00});
    @(posedge clk);
    #1;
    v1 = 1'b0;
    v3 = 1'b0;
  endtask

  task automatic wait_resp(input int exp_lat, input logic [31:0] exp_data, input logic [4:0] exp_rd,
                           input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check({tag, " busy in wait"}, s_busy, 1);
        check({tag, " ready in wait"}, s_ready, 0);
        check({tag, " mem_en in wait"}, s_en, 0);
      end
    end while (!s_rvalid && n < 40);
    check({tag, " latency"}, n, exp_lat);
    check({tag, " data"}, s_data, exp_data);
    check({tag, " rd"}, s_rd, exp_rd);
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check("resp_valid after hs", s_rvalid, 0);
    check("ready after hs", s_ready, 1);
    check("busy after hs", s_busy, 0);
  endtask

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  func;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{32'h100, 3'b010, 5'd7,  32'h8070F0A5};
    vecs[1] = '{32'h103, 3'b000, 5'd1,  32'hFFFFFF80};
    vecs[2] = '{32'h103, 3'b100, 5'd2,  32'h00000080};
    vecs[3] = '{32'h100, 3'b000, 5'd3,  32'hFFFFFFA5};
    vecs[4] = '{32'h101, 3'b100, 5'd4,  32'h000000F0};
    vecs[5] = '{32'h102, 3'b001, 5'd5,  32'hFFFF8070};
    vecs[6] = '{32'h103, 3'b001, 5'd6,  32'hFFFF8070};
    vecs[7] = '{32'h101, 3'b101, 5'd8,  32'h0000F0A5};
    vecs[8] = '{32'h100, 3'b001, 5'd30, 32'hFFFFF0A5};
    vecs[9] = '{32'h100, 3'b111, 5'd31, 32'h8070F0A5};

    rst_n = 1'b0; v1 = 1'b1; v3 = 1'b0; addr = 32'h100; func = 3'b010; rd = 5'd0;
    resp_ready = 1'b0; sel3 = 1'b0;
    #12;
    check("reset resp_valid", a1.resp_valid_out, 0);
    check("reset busy", busy1, 0);
    check("reset mem_en", a1.mem_en_out, 0);
    check("reset req_ready", a1.req_ready_out, 0);
    check("reset resp_data", a1.resp_data_out, 0);
    check("reset resp_rd", a1.resp_rd_out, 0);
    v1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      issue(1'b0, vecs[i].addr, vecs[i].func, vecs[i].rd);
      wait_resp(2, vecs[i].exp, vecs[i].rd, $sformatf("vec%0d", i));
      handshake();
    end

    // Backpressure with a pending request waiting behind the held response.
    issue(1'b0, 32'h100, 3'b010, 5'd9);
    wait_resp(2, 32'h8070F0A5, 5'd9, "bp");
    addr = 32'h103; func = 3'b000; rd = 5'd3; v1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp resp_valid held", s_rvalid, 1);
      check("bp data stable", s_data, 32'h8070F0A5);
      check("bp rd stable", s_rd, 9);
      check("bp req_ready", s_ready, 0);
      check("bp mem_en", s_en, 0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    #1;
    check("hs cycle no accept", s_ready, 0);
    check("hs cycle no mem_en", s_en, 0);
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check("post-hs ready", s_ready, 1);
    check("post-hs mem_en", s_en, 1);
    check("post-hs resp_valid", s_rvalid, 0);
    @(posedge clk);
    #1;
    v1 = 1'b0;
    wait_resp(2, 32'hFFFFFF80, 5'd3, "bp next");
    handshake();

    // Longer read latency: garbage data before the capture cycle must be ignored.
    issue(1'b1, 32'h200, 3'b010, 5'd12);
    wait_resp(4, 32'h12345678, 5'd12, "rl3");
    handshake();

    // Asynchronous reset in WAIT.
    issue(1'b1, 32'h100, 3'b000, 5'd5);
    @(negedge clk);
    check("pre-reset busy", s_busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst wait busy", s_busy, 0);
    check("rst wait resp_valid", s_rvalid, 0);
    v3 = 1'b1;
    #1;
    check("rst wait mem_en", s_en, 0);
    check("rst wait ready", s_ready, 0);
    v3 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b1, 32'h102, 3'b001, 5'd2);
    wait_resp(4, 32'hFFFF8070, 5'd2, "rl3 after rst");
    handshake();

    // Asynchronous reset in RESP.
    issue(1'b0, 32'h101, 3'b100, 5'd6);
    wait_resp(2, 32'h000000F0, 5'd6, "pre-rst resp");
    #2;
    rst_n = 1'b0;
    #1;
    check("rst resp resp_valid", s_rvalid, 0);
    check("rst resp busy", s_busy, 0);
    check("rst resp mem_en", s_en, 0);
    check("rst resp data cleared", s_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, 32'h103, 3'b000, 5'd1);
    wait_resp(2, 32'hFFFFFF80, 5'd1, "after rst");
    handshake();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_load_unit.md
Name: mem_load_unit

Overview:
- Read-side counterpart of the core's store data/byte-enable generator.
- Accepts one load request at a time from the MEM stage.
- Issues a word-aligned read to a synchronous data memory, waits a fixed read latency, then extracts the addressed byte/halfword/word with sign or zero extension.
- Returns the result with the destination register tag over a valid/ready handshake to writeback.

Parameters:
DATA_WIDTH, 32, memory word and result width
ADDR_WIDTH, 32, byte address width
READ_LATENCY, 1, cycles from mem_en_out to valid mem_rdata_in; legal range 1..15
RD_WIDTH, 5, destination register tag width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid_in  input  1  load request valid
req_ready_out  output  1  unit can accept a request
req_addr_in  input  ADDR_WIDTH  byte address
req_func_in  input  3  load funct3 (LB/LH/LW/LBU/LHU)
req_rd_in  input  RD_WIDTH  destination register tag
mem_en_out  output  1  memory read enable
mem_addr_out  output  ADDR_WIDTH  word-aligned read address
mem_rdata_in  input  DATA_WIDTH  memory read data
resp_valid_out  output  1  result valid
resp_ready_in  input  1  consumer accepts result
resp_data_out  output  DATA_WIDTH  extracted, extended load data
resp_rd_out  output  RD_WIDTH  tag of the returned load
busy_out  output  1  high in WAIT or RESP

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset: state=IDLE, counter=0, latched offset/func/rd=0, resp_data_out=0, resp_rd_out=0, resp_valid_out=0, busy_out=0, mem_en_out=0.
- While rst_n is low, req_ready_out=0 and requests are ignored.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready_out=1; mem_en_out = req_valid_in (combinational); mem_addr_out = {req_addr_in[ADDR_WIDTH-1:2], 2'b00}.
  - On req_valid_in & req_ready_out: latch req_addr_in[1:0], req_func_in, req_rd_in; load counter=READ_LATENCY-1; go to WAIT.
- WAIT:
  - req_ready_out=0, mem_en_out=0, busy_out=1.
  - If counter!=0: decrement.
  - If counter==0: sample mem_rdata_in, extract into the resp_data_out register, go to RESP.
- RESP:
  - resp_valid_out=1; resp_data_out and resp_rd_out held stable.
  - On resp_ready_in: go to IDLE. No new request is accepted in the same cycle.
- Latency: request accepted in cycle 0 → mem_rdata_in sampled at end of cycle READ_LATENCY → resp_valid_out high from cycle READ_LATENCY+1. Minimum spacing between accepts is READ_LATENCY+2 cycles.
- Extraction (off = latched byte offset; W = memory word):
  - LB (000): sign-extend W[8*off+7:8*off].
  - LBU (100): zero-extend the same byte.
  - LH (001): halfword select hoff = {off[1],1'b0}, so offsets 1 and 3 round down to 0 and 2 (same rule as the store side); sign-extend W[8*hoff+15:8*hoff].
  - LHU (101): zero-extend the same halfword.
  - LW (010): W unchanged; off ignored.
  - Unsupported funct3 (011/110/111): treated as LW. No error is flagged.
- Backpressure: resp_valid_out stays high indefinitely until resp_ready_in. req_ready_out stays 0 throughout.
- Reset mid-operation: any state returns to IDLE immediately. An in-flight result is discarded. Late mem_rdata_in is ignored.
- mem_rdata_in is don't-care outside the capture cycle.

Test Plan:
- Memory word at 0x100 = 0x8070F0A5, READ_LATENCY=1, LW addr 0x100, rd=7 → mem_en_out=1 and mem_addr_out=0x100 in cycle 0; resp_valid_out high in cycle 2 with resp_data_out=0x8070F0A5, resp_rd_out=7.
- Byte loads on the same word → LB 0x103 = 0xFFFFFF80; LBU 0x103 = 0x00000080; LB 0x100 = 0xFFFFFFA5; LBU 0x101 = 0x000000F0.
- Halfword loads → LH 0x102 and LH 0x103 both = 0xFFFF8070; LHU 0x101 = 0x0000F0A5; LH 0x100 = 0xFFFFF0A5; funct3=111 at 0x100 = 0x8070F0A5.
- Backpressure: hold resp_ready_in=0 for 5 cycles with req_valid_in=1 → resp_data_out and resp_rd_out stable; req_ready_out=0; mem_en_out=0. After the handshake, the next request is accepted one cycle later in IDLE.
- READ_LATENCY=3, mem_rdata_in=0xDEADBEEF in cycles 1–2 and 0x12345678 in cycle 3, LW → resp_data_out=0x12345678, resp_valid_out rising in cycle 4.
- Drive rst_n low asynchronously mid-WAIT and again mid-RESP → resp_valid_out, busy_out, mem_en_out go to 0 without a clock edge. After release, LB 0x103 returns 0xFFFFFF80 with correct latency.
